// File: rtl/vga_pkg.sv
// Shared timing constants and pixel format for the 640x480@60 Hz scanout path.
package vga_pkg;

  // Default 640x480@60 Hz timing at a 25.2 MHz pixel clock.
  localparam int DEF_H_ACTIVE  = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_ACTIVE  = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;
  localparam int DEF_PIXEL_LAT = 3;

  // Derived timing: totals and sync windows (END is exclusive).
  localparam int H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int HS_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int HS_END   = HS_START + DEF_H_SYNC;
  localparam int VS_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int VS_END   = VS_START + DEF_V_SYNC;

  // RGB565 word as returned by the drawer.
  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  // Split a raw 16-bit RGB565 word into its colour fields.
  function automatic rgb565_t unpack_rgb565(input logic [15:0] word);
    return rgb565_t'(word);
  endfunction

endpackage

// File: rtl/vga_scanout_sync_delay.sv
// Fixed-depth shift register with a per-bit reset value; used to align
// sync/blank with the drawer's pixel return latency.
module sync_delay
  import vga_pkg::*;
#(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sr_q [DEPTH];

  // Shift one stage per clock; reset loads the idle (inactive) pattern.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) sr_q[i] <= RST_VAL;
    end else begin
      sr_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/vga_scanout.sv
// VGA raster generator: drives 320x240 logical coordinates to the drawer,
// takes RGB565 back after PIXEL_LAT clocks and emits pixel-doubled colour
// with sync/blank aligned to the same pixel.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter int PIXEL_LAT = DEF_PIXEL_LAT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pixel_data,
  output logic [8:0]  x,
  output logic [8:0]  y,
  output logic        clk_vsync,
  output logic [4:0]  vga_r,
  output logic [5:0]  vga_g,
  output logic [4:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n
);

  // Timing derived from this instance's parameters, in counter width.
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HS_LO  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_HI  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_LO  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_HI  = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [8:0] X_LAST = 9'(H_ACTIVE / 2 - 1);
  localparam logic [8:0] Y_LAST = 9'(V_ACTIVE / 2 - 1);

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;

  logic [8:0] x_q, x_d;
  logic [8:0] y_q, y_d;
  logic       hs_raw_q, hs_raw_d;
  logic       vs_raw_q, vs_raw_d;
  logic       blank_raw_q, blank_raw_d;

  logic [2:0] sync_dly;
  logic       hs_dly, vs_dly, blank_dly;

  rgb565_t    rgb_q, rgb_d;
  logic       hs_q, vs_q, blank_n_q;

  // Raster counters: h wraps every line, v advances on each h wrap.
  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
    end
  end

  // Counter state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Coordinate/sync decode: halve counters for pixel doubling, clamp in blanking.
  always_comb begin
    x_d         = (h_cnt_q < H_ACT) ? h_cnt_q[9:1] : X_LAST;
    y_d         = (v_cnt_q < V_ACT) ? v_cnt_q[9:1] : Y_LAST;
    hs_raw_d    = !((h_cnt_q >= HS_LO) && (h_cnt_q < HS_HI));
    vs_raw_d    = !((v_cnt_q >= VS_LO) && (v_cnt_q < VS_HI));
    blank_raw_d = !((h_cnt_q < H_ACT) && (v_cnt_q < V_ACT));
  end

  // ---- stage 1: coordinates to drawer, raw sync/blank ----
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q         <= '0;
      y_q         <= '0;
      hs_raw_q    <= 1'b1;
      vs_raw_q    <= 1'b1;
      blank_raw_q <= 1'b1;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      hs_raw_q    <= hs_raw_d;
      vs_raw_q    <= vs_raw_d;
      blank_raw_q <= blank_raw_d;
    end
  end

  // ---- stage 2: sync/blank delayed to match the drawer's pixel return ----
  sync_delay #(
    .WIDTH  (3),
    .DEPTH  (PIXEL_LAT),
    .RST_VAL(3'b111)
  ) u_sync_delay (
    .clk_i(clk),
    .rst_i(rst),
    .d_i  ({hs_raw_q, vs_raw_q, blank_raw_q}),
    .q_o  (sync_dly)
  );

  assign {hs_dly, vs_dly, blank_dly} = sync_dly;

  // Colour gate: nothing from the drawer reaches the DAC during blanking.
  always_comb begin
    rgb_d = '0;
    if (!blank_dly) rgb_d = unpack_rgb565(pixel_data);
  end

  // ---- stage 3: VGA pins, colour and sync on the same pixel ----
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q     <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
    end else begin
      rgb_q     <= rgb_d;
      hs_q      <= hs_dly;
      vs_q      <= vs_dly;
      blank_n_q <= !blank_dly;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign clk_vsync   = !vs_raw_q;
  assign vga_r       = rgb_q.r;
  assign vga_g       = rgb_q.g;
  assign vga_b       = rgb_q.b;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_n_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout. Horizontal timing is the real 800-clock
// line; the vertical period is shortened to 15 lines so whole frames fit
// in a short run. Cycle 0 is the clock after the last reset edge (h_cnt=0).
module tb_vga_scanout;

  localparam int TB_V_ACTIVE = 8;
  localparam int TB_V_FP     = 2;
  localparam int TB_V_SYNC   = 2;
  localparam int TB_V_BP     = 3;
  localparam int LAT         = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pix = 16'h0000;
  logic [8:0]  x, y;
  logic        clk_vsync;
  logic [4:0]  vga_r, vga_b;
  logic [5:0]  vga_g;
  logic        vga_hs, vga_vs, vga_blank_n;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  vga_scanout #(
    .V_ACTIVE (TB_V_ACTIVE),
    .V_FP     (TB_V_FP),
    .V_SYNC   (TB_V_SYNC),
    .V_BP     (TB_V_BP),
    .PIXEL_LAT(LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pixel_data (pix),
    .x          (x),
    .y          (y),
    .clk_vsync  (clk_vsync),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .vga_hs     (vga_hs),
    .vga_vs     (vga_vs),
    .vga_blank_n(vga_blank_n)
  );

  always #20 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    pix = 16'hFFFF;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({x, y} !== 18'd0) begin
      fails++; $display("FAIL reset_xy got x=%0d y=%0d want 0 0", x, y);
    end
    tests++;
    if ({vga_r, vga_g, vga_b} !== 16'h0000 || clk_vsync !== 1'b0) begin
      fails++; $display("FAIL reset_rgb got %h vsync=%b want 0000 0", {vga_r, vga_g, vga_b}, clk_vsync);
    end
    tests++;
    if ({vga_hs, vga_vs, vga_blank_n} !== 3'b110) begin
      fails++; $display("FAIL reset_sync got hs/vs/bn=%b want 110", {vga_hs, vga_vs, vga_blank_n});
    end
    rst = 1'b0;
    cyc = 0;
    // Delay line still flushing its reset pattern through cycle 4.
    repeat (4) step();
    tests++;
    if ({vga_blank_n, vga_r, vga_g, vga_b} !== 17'h0 || vga_hs !== 1'b1) begin
      fails++; $display("FAIL reset_flush cyc=%0d got bn=%b rgb=%h hs=%b want 0 0000 1",
                        cyc, vga_blank_n, {vga_r, vga_g, vga_b}, vga_hs);
    end
    step();
    tests++;
    if (vga_blank_n !== 1'b1 || vga_r !== 5'd31 || vga_g !== 6'd63 || vga_b !== 5'd31) begin
      fails++; $display("FAIL first_pixel cyc=%0d got bn=%b r=%0d g=%0d b=%0d want 1 31 63 31",
                        cyc, vga_blank_n, vga_r, vga_g, vga_b);
    end
  endtask

  task automatic test_hsync();
    int f1 = -1, r1 = -1, f2 = -1;
    logic prev;
    pix = 16'h0000;
    do_reset();
    prev = vga_hs;
    while (cyc < 1500) begin
      step();
      if (prev && !vga_hs) begin
        if (f1 < 0) f1 = cyc; else if (f2 < 0) f2 = cyc;
      end
      if (!prev && vga_hs && r1 < 0) r1 = cyc;
      prev = vga_hs;
    end
    tests++;
    if (f1 != 661) begin
      fails++; $display("FAIL hs_first_fall got %0d want 661", f1);
    end
    tests++;
    if (r1 - f1 != 96) begin
      fails++; $display("FAIL hs_width got %0d want 96", r1 - f1);
    end
    tests++;
    if (f2 - f1 != 800) begin
      fails++; $display("FAIL hs_period got %0d want 800", f2 - f1);
    end
  endtask

  task automatic test_coord();
    int bad_hold = 0;
    do_reset();
    while (cyc < 1601) begin
      step();
      if (cyc == 2) begin
        tests++;
        if (x !== 9'd0) begin fails++; $display("FAIL x_h1 got %0d want 0", x); end
      end
      if (cyc == 3) begin
        tests++;
        if (x !== 9'd1) begin fails++; $display("FAIL x_h2 got %0d want 1", x); end
      end
      if (cyc == 639) begin
        tests++;
        if (x !== 9'd319) begin fails++; $display("FAIL x_h638 got %0d want 319", x); end
      end
      if (cyc >= 640 && cyc <= 800 && x !== 9'd319) bad_hold++;
      if (cyc == 801) begin
        tests++;
        if (x !== 9'd0 || y !== 9'd0) begin
          fails++; $display("FAIL x_newline got x=%0d y=%0d want 0 0", x, y);
        end
      end
      if (cyc == 1601) begin
        tests++;
        if (y !== 9'd1) begin fails++; $display("FAIL y_line2 got %0d want 1", y); end
      end
    end
    tests++;
    if (bad_hold != 0) begin
      fails++; $display("FAIL x_hblank_hold got %0d bad cycles want 0", bad_hold);
    end
  endtask

  task automatic test_latency();
    int c = -1;
    logic [15:0] pat [3] = '{16'h07E0, 16'h001F, 16'hA5A5};
    logic [15:0] exp [3] = '{{5'd0, 6'd63, 5'd0}, {5'd0, 6'd0, 5'd31}, {5'd20, 6'd45, 5'd5}};
    pix = 16'h0000;
    do_reset();
    while (c < 0 && cyc < 1000) begin
      step();
      if (x == 9'd5) c = cyc;
    end
    tests++;
    if (c != 11) begin fails++; $display("FAIL x5_first got %0d want 11", c); end
    repeat (3) step();
    tests++;
    if (vga_r !== 5'd0) begin fails++; $display("FAIL lat_before got r=%0d want 0", vga_r); end
    pix = 16'hF800;
    step();
    pix = 16'h0000;
    tests++;
    if (vga_r !== 5'd31 || vga_g !== 6'd0 || vga_b !== 5'd0 || vga_blank_n !== 1'b1) begin
      fails++; $display("FAIL lat_red got r=%0d g=%0d b=%0d bn=%b want 31 0 0 1",
                        vga_r, vga_g, vga_b, vga_blank_n);
    end
    step();
    tests++;
    if (vga_r !== 5'd0) begin fails++; $display("FAIL lat_after got r=%0d want 0", vga_r); end
    for (int i = 0; i < 3; i++) begin
      pix = pat[i];
      step();
      tests++;
      if ({vga_r, vga_g, vga_b} !== exp[i]) begin
        fails++; $display("FAIL rgb_split_%0d got %h want %h", i, {vga_r, vga_g, vga_b}, exp[i]);
      end
    end
    pix = 16'h0000;
  endtask

  task automatic test_frame();
    int rise1 = -1, rise2 = -1, vfall = -1, nrise = 0;
    int vsfall = -1, vsrise = -1;
    int gate_bad = 0, bn_bad = 0, first_bad = -1;
    logic pv, ps, exp_bn;
    int j;
    pix = 16'hFFFF;
    do_reset();
    pv = clk_vsync;
    ps = vga_vs;
    while (cyc < 20100) begin
      step();
      if (!pv && clk_vsync) begin
        nrise++;
        if (rise1 < 0) rise1 = cyc; else if (rise2 < 0) rise2 = cyc;
      end
      if (pv && !clk_vsync && vfall < 0) vfall = cyc;
      if (ps && !vga_vs && vsfall < 0) vsfall = cyc;
      if (!ps && vga_vs && vsrise < 0) vsrise = cyc;
      pv = clk_vsync;
      ps = vga_vs;
      j = cyc - (2 + LAT);
      exp_bn = (j >= 0) && ((j % 800) < 640) && (((j / 800) % 15) < TB_V_ACTIVE);
      if (vga_blank_n !== exp_bn) begin
        bn_bad++; if (first_bad < 0) first_bad = cyc;
      end
      if (vga_blank_n ? ({vga_r, vga_g, vga_b} !== 16'hFFFF) : ({vga_r, vga_g, vga_b} !== 16'h0000)) begin
        gate_bad++; if (first_bad < 0) first_bad = cyc;
      end
      if (cyc == 4801 || cyc == 6401 || cyc == 12000) begin
        tests++;
        if (y !== 9'd3) begin fails++; $display("FAIL y_clamp cyc=%0d got %0d want 3", cyc, y); end
      end
      if (cyc == 12001) begin
        tests++;
        if (x !== 9'd0 || y !== 9'd0) begin
          fails++; $display("FAIL frame_wrap got x=%0d y=%0d want 0 0", x, y);
        end
      end
    end
    tests++;
    if (rise1 != 8001) begin fails++; $display("FAIL vsync_first_rise got %0d want 8001", rise1); end
    tests++;
    if (vfall - rise1 != 1600) begin fails++; $display("FAIL vsync_width got %0d want 1600", vfall - rise1); end
    tests++;
    if (rise2 - rise1 != 12000 || nrise != 2) begin
      fails++; $display("FAIL vsync_period got %0d x%0d want 12000 x2", rise2 - rise1, nrise);
    end
    tests++;
    if (vsfall - rise1 != LAT + 1 || vsrise - vsfall != 1600) begin
      fails++; $display("FAIL vga_vs_align got delay %0d width %0d want %0d 1600",
                        vsfall - rise1, vsrise - vsfall, LAT + 1);
    end
    tests++;
    if (bn_bad != 0) begin fails++; $display("FAIL blank_map got %0d bad (first %0d) want 0", bn_bad, first_bad); end
    tests++;
    if (gate_bad != 0) begin fails++; $display("FAIL blank_gate got %0d bad (first %0d) want 0", gate_bad, first_bad); end
    pix = 16'h0000;
  endtask

  task automatic test_midreset();
    int f1 = -1;
    logic prev;
    do_reset();
    while (cyc < 4700) step();
    tests++;
    if (vga_hs !== 1'b0 || x !== 9'd319 || y !== 9'd2) begin
      fails++; $display("FAIL pre_reset got hs=%b x=%0d y=%0d want 0 319 2", vga_hs, x, y);
    end
    rst = 1'b1;
    step();
    tests++;
    if (x !== 9'd0 || y !== 9'd0 || vga_hs !== 1'b1 || vga_vs !== 1'b1 || vga_blank_n !== 1'b0) begin
      fails++; $display("FAIL mid_reset got x=%0d y=%0d hs=%b vs=%b bn=%b want 0 0 1 1 0",
                        x, y, vga_hs, vga_vs, vga_blank_n);
    end
    rst = 1'b0;
    cyc = 0;
    prev = vga_hs;
    while (cyc < 800 && f1 < 0) begin
      step();
      if (prev && !vga_hs) f1 = cyc;
      prev = vga_hs;
    end
    tests++;
    if (f1 != 661) begin fails++; $display("FAIL restart_hs_fall got %0d want 661", f1); end
  endtask

  initial begin
    test_reset();
    test_hsync();
    test_coord();
    test_latency();
    test_frame();
    test_midreset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
